// File: rtl/matrix_mult_nocache_pkg.sv
// Shared types and default widths for the matrix datapath's sequential divider.
package matrix_mult_nocache_pkg;

    localparam int DIV_DIVIDEND_W = 32;
    localparam int DIV_DIVISOR_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/matrix_mult_nocache_sdiv_step.sv
// One restoring-division step on magnitudes: shift {rem, q} left, subtract divisor if it fits.
module matrix_mult_nocache_sdiv_step #(
    parameter int NW = 32,
    parameter int DW = 16
) (
    input  logic [DW:0]   rem_i,
    input  logic [NW-1:0] q_i,
    input  logic [DW:0]   div_i,
    output logic [DW:0]   rem_o,
    output logic [NW-1:0] q_o
);

    logic        [DW:0]   shifted;
    logic signed [DW+1:0] trial;

    always_comb begin
        // Partial remainder stays below the divisor, so its top bit is free to drop on the shift.
        shifted = {rem_i[DW-1:0], q_i[NW-1]};
        trial   = $signed({1'b0, shifted}) - $signed({1'b0, div_i});
        if (trial >= 0) begin
            rem_o = trial[DW:0];
            q_o   = {q_i[NW-2:0], 1'b1};
        end else begin
            rem_o = shifted;
            q_o   = {q_i[NW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/matrix_mult_nocache_sdiv_32s_16s_seq.sv
// Sequential 32s/16s signed divider with start/done handshake and clock enable.
// Optional divide-by-zero fast path and dbz flag: define MATRIXMULT_NOCACHE_SDIV_DBZ_EN.
module matrix_mult_nocache_sdiv_32s_16s_seq
    import matrix_mult_nocache_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIV_DIVIDEND_W,
    parameter int din1_WIDTH = DIV_DIVISOR_W,
    parameter int dout_WIDTH = DIV_DIVIDEND_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem
`ifdef MATRIXMULT_NOCACHE_SDIV_DBZ_EN
    ,
    output logic                  dbz
`endif
);

    localparam int NW = din0_WIDTH;
    localparam int DW = din1_WIDTH;
    localparam int CW = $clog2(din0_WIDTH);

    if (dout_WIDTH != din0_WIDTH || ID < 0) begin : g_bad_cfg
        $error("dout_WIDTH must equal din0_WIDTH");
    end

    function automatic logic [NW-1:0] cneg_q(input logic [NW-1:0] v, input logic neg);
        return neg ? NW'(-v) : v;
    endfunction

    function automatic logic [DW:0] cneg_d(input logic [DW:0] v, input logic neg);
        return neg ? (DW+1)'(-v) : v;
    endfunction

    function automatic logic [DW-1:0] cneg_r(input logic [DW-1:0] v, input logic neg);
        return neg ? DW'(-v) : v;
    endfunction

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] q_q, q_d;
    logic [DW:0]   div_q, div_d;
    logic [DW:0]   prem_q, prem_d;
    logic          neg_quot_q, neg_quot_d;
    logic          neg_rem_q, neg_rem_d;
    logic [NW-1:0] quot_q, quot_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW:0]   step_rem;
    logic [NW-1:0] step_q;
`ifdef MATRIXMULT_NOCACHE_SDIV_DBZ_EN
    logic          dbz_q, dbz_d;
`endif

    matrix_mult_nocache_sdiv_step #(.NW(NW), .DW(DW)) u_step (
        .rem_i (prem_q),
        .q_i   (q_q),
        .div_i (div_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        q_d        = q_q;
        div_d      = div_q;
        prem_d     = prem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
`ifdef MATRIXMULT_NOCACHE_SDIV_DBZ_EN
        dbz_d      = dbz_q;
`endif
        if (ce) begin
            case (state_q)
                IDLE: if (start) begin
                    // Magnitudes in unsigned registers; -2^31 and -2^15 keep their true size.
                    q_d        = cneg_q(din0, din0[NW-1]);
                    div_d      = cneg_d({din1[DW-1], din1}, din1[DW-1]);
                    prem_d     = '0;
                    neg_quot_d = din0[NW-1] ^ din1[DW-1];
                    neg_rem_d  = din0[NW-1];
                    cnt_d      = CW'(NW - 1);
                    state_d    = CALC;
`ifdef MATRIXMULT_NOCACHE_SDIV_DBZ_EN
                    dbz_d      = 1'b0;
                    if (din1 == '0) state_d = FIX;
`endif
                end
                CALC: begin
                    q_d    = step_q;
                    prem_d = step_rem;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) state_d = FIX;
                end
                FIX: begin
                    quot_d  = cneg_q(q_q, neg_quot_q);
                    rem_d   = cneg_r(prem_q[DW-1:0], neg_rem_q);
`ifdef MATRIXMULT_NOCACHE_SDIV_DBZ_EN
                    // q still holds |din0|; re-applying the sign recovers din0's low bits.
                    if (div_q == '0) begin
                        quot_d = '1;
                        rem_d  = cneg_r(q_q[DW-1:0], neg_rem_q);
                        dbz_d  = 1'b1;
                    end
`endif
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef MATRIXMULT_NOCACHE_SDIV_DBZ_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
`ifdef MATRIXMULT_NOCACHE_SDIV_DBZ_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        cnt_q      <= cnt_d;
        q_q        <= q_d;
        div_q      <= div_d;
        prem_q     <= prem_d;
        neg_quot_q <= neg_quot_d;
        neg_rem_q  <= neg_rem_d;
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE) && ce;
    assign quot  = quot_q;
    assign rem   = rem_q;
`ifdef MATRIXMULT_NOCACHE_SDIV_DBZ_EN
    assign dbz   = dbz_q;
`endif

endmodule

// File: tb/tb_matrix_mult_nocache_sdiv_32s_16s_seq.sv
// Self-checking bench for the sequential signed divider against a plain-arithmetic model.
module tb_matrix_mult_nocache_sdiv_32s_16s_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic        start = 1'b0;
    logic [31:0] din0 = '0;
    logic [15:0] din1 = '0;
    logic        ready, done;
    logic [31:0] quot;
    logic [15:0] rem;
`ifdef MATRIXMULT_NOCACHE_SDIV_DBZ_EN
    logic        dbz;
    localparam bit DBZ_EN = 1'b1;
`else
    logic        dbz = 1'b0;
    localparam bit DBZ_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_mult_nocache_sdiv_32s_16s_seq dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (start),
        .din0  (din0),
        .din1  (din1),
        .ready (ready),
        .done  (done),
        .quot  (quot),
        .rem   (rem)
`ifdef MATRIXMULT_NOCACHE_SDIV_DBZ_EN
        ,
        .dbz   (dbz)
`endif
    );

    function automatic void ref_div(input logic [31:0] a, input logic [15:0] b,
                                    output logic [31:0] q, output logic [15:0] r);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint lq, lr;
        if (sb == 0) begin
            q = (DBZ_EN || sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
            r = a[15:0];
        end else begin
            lq = sa / sb;
            lr = sa % sb;
            q = lq[31:0];
            r = lr[15:0];
        end
    endfunction

    function automatic int ref_lat(input logic [15:0] b, input int stall);
        return (DBZ_EN && b == 16'd0) ? 2 : 34 + stall;
    endfunction

    // Caller is just past a negedge. Starts a division in the current cycle (cycle 0).
    task automatic run_div(input logic [31:0] a, input logic [15:0] b,
                           input int ce_from, input int ce_len, input int again_at,
                           output int lat, output logic rdy0, output logic rdy1,
                           output logic rdy_after, output logic [31:0] oq, output logic [15:0] orr);
        din0 = a; din1 = b; start = 1'b1; ce = 1'b1;
        #1 rdy0 = ready;
        lat = -1; rdy1 = 1'bx; rdy_after = 1'bx; oq = 'x; orr = 'x;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start = (n == again_at);
            din0 = $urandom; din1 = 16'($urandom);
            ce = !(n >= ce_from && n < ce_from + ce_len);
            #1;
            if (n == 1) rdy1 = ready;
            if (done) begin
                lat = n; oq = quot; orr = rem;
                break;
            end
        end
        start = 1'b0; ce = 1'b1;
        if (lat > 0) begin
            @(negedge clk);
            #1 rdy_after = ready;
        end
    endtask

    task automatic check_div(input string name, input logic [31:0] a, input logic [15:0] b,
                             input int ce_from, input int ce_len, input int again_at);
        int lat; logic r0, r1, ra; logic [31:0] oq, eq; logic [15:0] orr, er;
        ref_div(a, b, eq, er);
        run_div(a, b, ce_from, ce_len, again_at, lat, r0, r1, ra, oq, orr);
        checks++; if (lat !== ref_lat(b, ce_len)) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, ref_lat(b, ce_len)); end
        checks++; if (oq !== eq) begin errors++; $display("FAIL %s quot got %h want %h", name, oq, eq); end
        checks++; if (orr !== er) begin errors++; $display("FAIL %s rem got %h want %h", name, orr, er); end
        checks++; if (r0 !== 1'b1 || r1 !== 1'b0 || ra !== 1'b1) begin errors++; $display("FAIL %s ready seq got %b%b%b want 101", name, r0, r1, ra); end
`ifdef MATRIXMULT_NOCACHE_SDIV_DBZ_EN
        checks++; if (dbz !== (b == 16'd0)) begin errors++; $display("FAIL %s dbz got %b want %b", name, dbz, b == 16'd0); end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL reset ready/done got %b/%b want 1/0", ready, done); end
        checks++; if (quot !== 32'd0 || rem !== 16'd0 || dbz !== 1'b0) begin errors++; $display("FAIL reset outputs got %h/%h/%b want 0/0/0", quot, rem, dbz); end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        check_div("100/7", 32'd100, 16'd7, 0, 0, 0);
        check_div("-100/7", -32'sd100, 16'd7, 0, 0, 0);
        check_div("100/-7", 32'd100, -16'sd7, 0, 0, 0);
        check_div("min/-1", 32'h8000_0000, 16'hFFFF, 0, 0, 0);
        check_div("max/-32768", 32'h7FFF_FFFF, 16'h8000, 0, 0, 0);
        check_div("-32768/-32768", 32'hFFFF_8000, 16'h8000, 0, 0, 0);
        check_div("1234/0", 32'd1234, 16'd0, 0, 0, 0);
        check_div("-1234/0", -32'sd1234, 16'd0, 0, 0, 0);
        check_div("after_zero", 32'd55, 16'd5, 0, 0, 0);
    endtask

    task automatic test_ce_stall();
        int seen = 0;
        check_div("ce_stall", 32'd100, 16'd7, 5, 5, 10);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1 if (!ready || done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL ignored_start busy cycles got %0d want 0", seen); end
    endtask

    task automatic test_reset_mid();
        int early = 0;
        @(negedge clk);
        din0 = 32'd999; din1 = 16'd3; start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 10) reset = 1'b1;
            #1 if (done) early++;
        end
        @(negedge clk);
        #1;
        checks++; if (ready !== 1'b1 || done !== 1'b0 || early !== 0) begin errors++; $display("FAIL reset_mid ready/done/early got %b/%b/%0d want 1/0/0", ready, done, early); end
        checks++; if (quot !== 32'd0 || rem !== 16'd0) begin errors++; $display("FAIL reset_mid outputs got %h/%h want 0/0", quot, rem); end
        reset = 1'b0;
        check_div("post_reset", 32'd100, 16'd7, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] a; logic [15:0] b; int from, len;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = 16'($urandom);
            if (i % 4 == 0) b = 16'($urandom_range(1, 9)) * ((i % 8 == 0) ? 16'hFFFF : 16'd1);
            if (b == 16'd0) b = 16'd3;
            from = $urandom_range(2, 30);
            len = $urandom_range(0, 4);
            check_div("random", a, b, from, len, $urandom_range(2, 30));
        end
    endtask

    task automatic test_back_to_back();
        check_div("b2b_a", -32'sd77777, 16'd123, 0, 0, 0);
        check_div("b2b_b", 32'd65536, -16'sd256, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ce_stall();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
